dijkstra_controller: RTL and testbench

Sequencing engine that drives PriorityQueue from the initiator side and runs single-source shortest path over an adjacency-weight memory. It initialises the queue with the source and repeatedly takes the queue's combinational min. It relaxes that node's outgoing edges by writing improved distances into the queue, and owns the visited/parent state that the queue consumes as prev_vector_flattened. It sits between the top-level start/result interface, the edge RAM and PriorityQueue.

---
 rtl/dijkstra_controller.sv | 149 ++++++++++++++
 tb/tb_dijkstra_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_controller.sv
// Single-source shortest-path sequencer driving an external PriorityQueue and an edge-weight RAM.
// Owns visited/parent state and publishes it to the queue as prev_vector_flattened.
module dijkstra_controller #(
  parameter int unsigned MAX_NODES   = 8,
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned VALUE_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source,
  output logic                             busy,
  output logic                             done,
  output logic [2*INDEX_WIDTH-1:0]         edge_addr,
  input  logic [VALUE_WIDTH-1:0]           edge_weight,
  output logic                             pq_reset,
  output logic                             pq_set_en,
  output logic [INDEX_WIDTH-1:0]           pq_index,
  output logic [VALUE_WIDTH-1:0]           pq_wdata,
  input  logic [VALUE_WIDTH-1:0]           pq_rdata,
  input  logic [INDEX_WIDTH-1:0]           pq_min_index,
  input  logic [VALUE_WIDTH-1:0]           pq_min_value,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  input  logic [INDEX_WIDTH-1:0]           query_index,
  output logic [VALUE_WIDTH-1:0]           query_dist
);

  localparam logic [VALUE_WIDTH-1:0] Infinity  = '1;
  localparam logic [INDEX_WIDTH-1:0] Unvisited = '1;
  localparam logic [INDEX_WIDTH-1:0] LastNode  = INDEX_WIDTH'(MAX_NODES - 1);

  typedef enum logic [2:0] {
    StIdle, StInit, StSelect, StEdgeReq, StEdgeWait, StRelax, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] source_q, source_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [VALUE_WIDTH-1:0] cur_dist_q, cur_dist_d;
  logic [INDEX_WIDTH-1:0] nbr_q, nbr_d;
  logic [MAX_NODES-1:0]   visited_q, visited_d;
  logic [INDEX_WIDTH-1:0] parent_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] parent_d [MAX_NODES];

  logic [VALUE_WIDTH:0]   sum;
  logic                   relax_ok;

  // Extra carry bit so an overflowing path can never look shorter than it is.
  assign sum = {1'b0, cur_dist_q} + {1'b0, edge_weight};
  assign relax_ok = (edge_weight != Infinity) && (nbr_q != cur_q) && !visited_q[nbr_q] &&
                    !sum[VALUE_WIDTH] && (sum[VALUE_WIDTH-1:0] != Infinity) &&
                    (sum[VALUE_WIDTH-1:0] < pq_rdata);

  // Address is held from EDGE_REQ through RELAX, so a 1-cycle RAM has data ready in RELAX.
  assign edge_addr  = {cur_q, nbr_q};
  assign busy       = (state_q != StIdle);
  assign query_dist = pq_rdata;
  assign pq_wdata   = sum[VALUE_WIDTH-1:0];

  always_comb begin
    prev_vector_flattened = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      prev_vector_flattened[j*INDEX_WIDTH +: INDEX_WIDTH] =
          visited_q[j] ? parent_q[j] : Unvisited;
    end
  end

  always_comb begin
    state_d    = state_q;
    source_d   = source_q;
    cur_d      = cur_q;
    cur_dist_d = cur_dist_q;
    nbr_d      = nbr_q;
    visited_d  = visited_q;
    parent_d   = parent_q;
    done       = 1'b0;
    pq_reset   = 1'b0;
    pq_set_en  = 1'b0;
    pq_index   = nbr_q;
    unique case (state_q)
      StIdle: begin
        pq_index = query_index;
        if (start) begin
          source_d  = source;
          visited_d = '0;
          for (int j = 0; j < MAX_NODES; j++) parent_d[j] = '0;
          state_d   = StInit;
        end
      end
      StInit: begin
        pq_reset = 1'b1;
        pq_index = source_q;
        state_d  = StSelect;
      end
      StSelect: begin
        if (visited_q[pq_min_index] || (pq_min_value == Infinity)) begin
          state_d = StDone;
        end else begin
          visited_d[pq_min_index] = 1'b1;
          if (pq_min_index == source_q) parent_d[pq_min_index] = source_q;
          cur_d      = pq_min_index;
          cur_dist_d = pq_min_value;
          nbr_d      = '0;
          state_d    = StEdgeReq;
        end
      end
      StEdgeReq:  state_d = StEdgeWait;
      StEdgeWait: state_d = StRelax;
      StRelax: begin
        if (relax_ok) begin
          pq_set_en       = 1'b1;
          parent_d[nbr_q] = cur_q;
        end
        if (nbr_q == LastNode) begin
          state_d = StSelect;
        end else begin
          nbr_d   = nbr_q + INDEX_WIDTH'(1);
          state_d = StEdgeReq;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      source_q   <= '0;
      cur_q      <= '0;
      cur_dist_q <= '0;
      nbr_q      <= '0;
      visited_q  <= '0;
      for (int j = 0; j < MAX_NODES; j++) parent_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      source_q   <= source_d;
      cur_q      <= cur_d;
      cur_dist_q <= cur_dist_d;
      nbr_q      <= nbr_d;
      visited_q  <= visited_d;
      parent_q   <= parent_d;
    end
  end

endmodule

// File: tb/tb_dijkstra_controller.sv
// Bench for dijkstra_controller: models edge RAM and PriorityQueue, checks runs against a
// plain-array Dijkstra reference on directed and random graphs.
module tb_dijkstra_controller;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int VW  = 8;
  localparam int INF = 255;
  localparam int U   = 3;
  localparam int LIMIT = 2000;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [IW-1:0]     source;
  logic              busy, done;
  logic [2*IW-1:0]   edge_addr;
  logic [VW-1:0]     edge_weight;
  logic              pq_reset, pq_set_en;
  logic [IW-1:0]     pq_index;
  logic [VW-1:0]     pq_wdata, pq_rdata;
  logic [IW-1:0]     pq_min_index;
  logic [VW-1:0]     pq_min_value;
  logic [IW*N-1:0]   prev_vector_flattened;
  logic [IW-1:0]     query_index;
  logic [VW-1:0]     query_dist;

  int checks   = 0;
  int failures = 0;

  dijkstra_controller #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock(clock), .reset(reset), .start(start), .source(source), .busy(busy), .done(done),
    .edge_addr(edge_addr), .edge_weight(edge_weight), .pq_reset(pq_reset),
    .pq_set_en(pq_set_en), .pq_index(pq_index), .pq_wdata(pq_wdata), .pq_rdata(pq_rdata),
    .pq_min_index(pq_min_index), .pq_min_value(pq_min_value),
    .prev_vector_flattened(prev_vector_flattened), .query_index(query_index),
    .query_dist(query_dist)
  );

  always #5 clock = ~clock;

  // Environment: synchronous edge RAM and a behavioural priority queue.
  logic [VW-1:0] w  [N][N];
  logic [VW-1:0] qd [N];
  logic          found;

  always_ff @(posedge clock) edge_weight <= w[edge_addr[2*IW-1:IW]][edge_addr[IW-1:0]];

  always_ff @(posedge clock) begin
    if (pq_reset) begin
      for (int i = 0; i < N; i++) qd[i] <= VW'(INF);
      qd[pq_index] <= '0;
    end else if (pq_set_en) begin
      qd[pq_index] <= pq_wdata;
    end
  end

  assign pq_rdata = qd[pq_index];

  always_comb begin
    pq_min_index = '0;
    pq_min_value = VW'(INF);
    found        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (prev_vector_flattened[i*IW +: IW] == IW'(U) && (!found || qd[i] < pq_min_value)) begin
        found        = 1'b1;
        pq_min_index = IW'(i);
        pq_min_value = qd[i];
      end
    end
  end

  // Reference results.
  int rd [N];
  int rp [N];
  bit rv [N];
  int ref_sel, ref_upd;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_graph();
    for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) w[a][b] = VW'(INF);
  endtask

  task automatic graph_basic();
    clear_graph();
    w[0][1] = 5; w[0][2] = 2; w[2][1] = 1; w[1][3] = 3;
  endtask

  // Textbook Dijkstra; a node counts as still queued if unvisited or its parent aliases UNVISITED.
  task automatic compute_ref(input int src);
    int best, s;
    for (int i = 0; i < N; i++) begin rd[i] = INF; rp[i] = U; rv[i] = 0; end
    rd[src] = 0; ref_sel = 0; ref_upd = 0;
    for (int it = 0; it <= N; it++) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if ((!rv[i] || rp[i] == U) && (best < 0 || rd[i] < rd[best])) best = i;
      if (best < 0 || rv[best] || rd[best] == INF) break;
      rv[best] = 1; ref_sel++;
      if (best == src) rp[best] = src;
      for (int j = 0; j < N; j++) begin
        if (w[best][j] != INF && j != best && !rv[j]) begin
          s = rd[best] + int'(w[best][j]);
          if (s < INF && s < rd[j]) begin rd[j] = s; rp[j] = best; ref_upd++; end
        end
      end
    end
  endtask

  task automatic run_case(input string name, input int src, input int glitch_at);
    int n, sets;
    bit got_done;
    compute_ref(src);
    @(negedge clock); start = 1'b1; source = IW'(src);
    @(negedge clock); start = 1'b0;
    n = 1; sets = 0; got_done = 0;
    check_eq({name, ".busy_first"}, int'(busy), 1);
    while (n < LIMIT) begin
      if (pq_set_en) sets++;
      if (done) begin got_done = 1; break; end
      start = (n == glitch_at);
      if (n == glitch_at) source = IW'(src ^ 1);
      @(negedge clock); n++;
    end
    start = 1'b0;
    check_eq({name, ".done_seen"}, int'(got_done), 1);
    check_eq({name, ".cycles"}, n, 1 + ref_sel * (1 + 3 * N) + 2);
    check_eq({name, ".set_count"}, sets, ref_upd);
    @(negedge clock);
    check_eq({name, ".done_pulse"}, int'(done), 0);
    check_eq({name, ".busy_after"}, int'(busy), 0);
    for (int i = 0; i < N; i++) begin
      query_index = IW'(i);
      #1;
      check_eq($sformatf("%s.dist%0d", name, i), int'(query_dist), rd[i]);
      check_eq($sformatf("%s.prev%0d", name, i), int'(prev_vector_flattened[i*IW +: IW]),
               rv[i] ? rp[i] : U);
    end
  endtask

  task automatic run_aborted(input int src, input int reset_at);
    int n;
    bit got_done;
    @(negedge clock); start = 1'b1; source = IW'(src);
    @(negedge clock); start = 1'b0;
    n = 1; got_done = 0;
    while (n < reset_at) begin
      if (done) got_done = 1;
      @(negedge clock); n++;
    end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) got_done = 1;
      @(negedge clock);
    end
    check_eq("abort.no_done", int'(got_done), 0);
    check_eq("abort.busy", int'(busy), 0);
    check_eq("abort.prev", int'(prev_vector_flattened), int'({N{IW'(U)}}));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; source = '0; query_index = '0;
    clear_graph();
    repeat (2) @(negedge clock);
    check_eq("rst.busy", int'(busy), 0);
    check_eq("rst.done", int'(done), 0);
    check_eq("rst.pq_set_en", int'(pq_set_en), 0);
    check_eq("rst.pq_reset", int'(pq_reset), 0);
    check_eq("rst.edge_addr", int'(edge_addr), 0);
    check_eq("rst.prev", int'(prev_vector_flattened), int'({N{IW'(U)}}));
    reset = 1'b0;

    graph_basic();
    run_case("basic_s0", 0, -1);
    check_eq("basic_s0.dist3_const", int'(qd[3]), 6);
    run_case("basic_s3", 3, -1);

    clear_graph(); w[0][1] = 200; w[1][2] = 100;
    run_case("overflow", 0, -1);

    clear_graph(); w[0][1] = 4; w[0][2] = 2; w[2][1] = 2;
    run_case("tie", 0, -1);

    graph_basic();
    run_case("glitch", 0, 10);

    run_aborted(0, 20);
    run_case("restart_s1", 1, -1);

    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          w[a][b] = ($urandom_range(0, 1) == 0) ? VW'(INF) : VW'($urandom_range(0, 140));
      run_case($sformatf("rand%0d", t), int'($urandom_range(0, N - 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
